// File: rtl/gpio_pad_pkg.sv
// Shared types and register-map constants for the GPIO pad controller.
// Address layout: CFG[0..N_PADS-1], then STATUS, then ID.
package gpio_pad_pkg;

    typedef enum logic [1:0] {
        MODE_IN   = 2'd0,
        MODE_OUT  = 2'd1,
        MODE_CORE = 2'd2,
        MODE_OD   = 2'd3
    } pad_mode_e;

    typedef struct packed {
        logic      irq_en;
        logic      filt_en;
        logic      cs;
        logic      sl;
        logic      pd;
        logic      pu;
        pad_mode_e mode;
    } pad_cfg_t;

    localparam int         CFG_BASE   = 0;
    // STATUS and ID offsets are relative to the end of the CFG block
    localparam int         STATUS_OFS = 0;
    localparam int         ID_OFS     = 1;
    localparam logic [7:0] ID_MAGIC   = 8'h47;

endpackage

// File: rtl/gpio_in_filter.sv
// One pad's input path: synchroniser, optional debounce, and a registered
// one-cycle pulse whenever the conditioned value changes.
module gpio_in_filter
    import gpio_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_y,
    input  logic filt_en,
    output logic core_in,
    output logic change
);

    localparam int            CW      = $clog2(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          nxt_cnt;
    logic                   nxt_in;

    assign s = sync_q[SYNC_STAGES-1];

    // Counter is held while unfiltered so toggling filt_en never glitches
    always_comb begin
        nxt_in  = core_in;
        nxt_cnt = cnt;
        if (!filt_en) begin
            nxt_in = s;
        end else if (s == core_in) begin
            nxt_cnt = '0;
        end else if (cnt == CNT_MAX) begin
            nxt_in  = s;
            nxt_cnt = '0;
        end else begin
            nxt_cnt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt     <= '0;
            core_in <= 1'b0;
            change  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_y};
            cnt     <= nxt_cnt;
            core_in <= nxt_in;
            change  <= nxt_in ^ core_in;
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Register-programmed GPIO pad control: per-pad drive/pull config, input
// conditioning, W1C edge status and a level interrupt.
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int N_PADS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 8,
    parameter int AW          = $clog2(N_PADS + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic [N_PADS-1:0] core_out,
    input  logic [N_PADS-1:0] core_oe,
    output logic [N_PADS-1:0] core_in,
    output logic              irq,
    output logic [N_PADS-1:0] pad_a,
    output logic [N_PADS-1:0] pad_oe,
    output logic [N_PADS-1:0] pad_ie,
    output logic [N_PADS-1:0] pad_pu,
    output logic [N_PADS-1:0] pad_pd,
    output logic [N_PADS-1:0] pad_sl,
    output logic [N_PADS-1:0] pad_cs,
    input  logic [N_PADS-1:0] pad_y
);

    localparam logic [AW-1:0] STATUS_ADDR = AW'(CFG_BASE + N_PADS + STATUS_OFS);
    localparam logic [AW-1:0] ID_ADDR     = AW'(CFG_BASE + N_PADS + ID_OFS);
    localparam logic [31:0]   ID_VAL      = {ID_MAGIC, 8'(N_PADS), 8'(FILT_CYCLES), 8'(SYNC_STAGES)};

    pad_cfg_t [N_PADS-1:0] cfg;
    logic     [N_PADS-1:0] status;
    logic     [N_PADS-1:0] w1c;
    logic     [N_PADS-1:0] chg;
    logic     [N_PADS-1:0] filt_en;
    logic     [N_PADS-1:0] irq_en;
    logic     [31:0]       rd_mux;

    gpio_in_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filt [N_PADS-1:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .pad_y   (pad_y),
        .filt_en (filt_en),
        .core_in (core_in),
        .change  (chg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= '0;
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                if (cfg_we && cfg_addr == AW'(CFG_BASE + i))
                    cfg[i] <= pad_cfg_t'(cfg_wdata[7:0]);
            end
        end
    end

    // Pad drive is combinational so reset releases the pads without a clock
    always_comb begin
        pad_a   = '0;
        pad_oe  = '0;
        pad_ie  = '1;
        pad_pu  = '0;
        pad_pd  = '0;
        pad_sl  = '0;
        pad_cs  = '0;
        filt_en = '0;
        irq_en  = '0;
        for (int i = 0; i < N_PADS; i++) begin
            case (cfg[i].mode)
                MODE_OUT: begin
                    pad_oe[i] = 1'b1;
                    pad_ie[i] = 1'b0;
                    pad_a[i]  = core_out[i];
                end
                MODE_CORE: begin
                    pad_oe[i] = core_oe[i];
                    pad_ie[i] = ~core_oe[i];
                    pad_a[i]  = core_out[i];
                end
                MODE_OD: begin
                    pad_oe[i] = ~core_out[i];
                end
                default: ;
            endcase
            pad_pu[i]  = cfg[i].pu;
            pad_pd[i]  = cfg[i].pd & ~cfg[i].pu;
            pad_sl[i]  = cfg[i].sl;
            pad_cs[i]  = cfg[i].cs;
            filt_en[i] = cfg[i].filt_en;
            irq_en[i]  = cfg[i].irq_en;
        end
    end

    assign w1c = (cfg_we && cfg_addr == STATUS_ADDR) ? cfg_wdata[N_PADS-1:0] : '0;

    // A new event in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status <= '0;
        else        status <= (status & ~w1c) | (chg & irq_en);
    end

    assign irq = |status;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_PADS; i++) begin
            if (cfg_addr == AW'(CFG_BASE + i))
                rd_mux = {24'h0, cfg[i]};
        end
        if (cfg_addr == STATUS_ADDR) rd_mux = 32'(status);
        if (cfg_addr == ID_ADDR)     rd_mux = ID_VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cfg_rdata <= '0;
        else if (cfg_re) cfg_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: register reads are scored through
// an expected-value queue, pad and input-path behaviour checked directly.
module tb_gpio_pad_ctrl;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_re = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic [N-1:0]  core_out = '0;
    logic [N-1:0]  core_oe = '0;
    logic [N-1:0]  core_in;
    logic          irq;
    logic [N-1:0]  pad_a, pad_oe, pad_ie, pad_pu, pad_pd, pad_sl, pad_cs;
    logic [N-1:0]  pad_y = '0;

    gpio_pad_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .core_out  (core_out),
        .core_oe   (core_oe),
        .core_in   (core_in),
        .irq       (irq),
        .pad_a     (pad_a),
        .pad_oe    (pad_oe),
        .pad_ie    (pad_ie),
        .pad_pu    (pad_pu),
        .pad_pd    (pad_pd),
        .pad_sl    (pad_sl),
        .pad_cs    (pad_cs),
        .pad_y     (pad_y)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic        rd_pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, act, exp);
        end
    endtask

    // Read data is valid the cycle after cfg_re is sampled
    always @(posedge clk) rd_pend <= cfg_re;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                chk(tag_q.pop_front(), cfg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        cfg_re   = 1'b1;
        cfg_addr = a;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk);
        cfg_re = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Counts clock edges until core_in[b] reaches v; bounded
    task automatic wait_in(input int b, input logic v, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (core_in[b] !== v && n < 40);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic seen;

        repeat (2) @(negedge clk);
        chk("rst_oe", 32'(pad_oe), 32'h00);
        chk("rst_ie", 32'(pad_ie), 32'hFF);
        chk("rst_a", 32'(pad_a), 32'h00);
        chk("rst_pulls", {pad_pu, pad_pd, pad_sl, pad_cs}, 32'h0);
        chk("rst_rdata", cfg_rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_core_in", 32'(core_in), 32'h0);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++)
            rd(AW'(a), (a == 9) ? 32'h4708_0802 : 32'h0, "rd_init");

        core_out[3] = 1'b1;
        wr(3, 32'h01);
        chk("out_oe", 32'(pad_oe[3]), 32'h1);
        chk("out_ie", 32'(pad_ie[3]), 32'h0);
        chk("out_a", 32'(pad_a[3]), 32'h1);
        wr(3, 32'h03);
        chk("od_hi_oe", 32'(pad_oe[3]), 32'h0);
        chk("od_hi_a", 32'(pad_a[3]), 32'h0);
        chk("od_hi_ie", 32'(pad_ie[3]), 32'h1);
        core_out[3] = 1'b0;
        #1 chk("od_lo_oe", 32'(pad_oe[3]), 32'h1);
        wr(3, 32'h02);
        core_oe[3] = 1'b1;
        #1 chk("core_oe", {pad_oe[3], pad_ie[3]}, 32'h2);
        core_oe[3] = 1'b0;
        #1 chk("core_ie", {pad_oe[3], pad_ie[3]}, 32'h1);

        wr(0, 32'h0C);
        chk("pu_pd_prio", {pad_pu[0], pad_pd[0]}, 32'h2);
        rd(0, 32'h0C, "rd_cfg0");
        wr(1, 32'h38);
        chk("pd_sl_cs", {pad_pu[1], pad_pd[1], pad_sl[1], pad_cs[1]}, 32'h7);
        wr(12, 32'hFF);
        rd(12, 32'h0, "rd_unmapped");

        wr(4, 32'h80);
        @(negedge clk);
        pad_y[4] = 1'b1;
        wait_in(4, 1'b1, n);
        chk("lat_unfilt", 32'(n), 32'd3);
        chk("irq_pre", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_unfilt", 32'(irq), 32'h1);
        rd(8, 32'h10, "status4");
        wr(8, 32'h10);
        chk("irq_clr4", 32'(irq), 32'h0);

        wr(2, 32'hC0);
        @(negedge clk);
        pad_y[2] = 1'b1;
        repeat (5) @(negedge clk);
        pad_y[2] = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (core_in[2] || irq) seen = 1'b1;
        end
        chk("filt_glitch", 32'(seen), 32'h0);

        @(negedge clk);
        pad_y[2] = 1'b1;
        wait_in(2, 1'b1, n);
        chk("lat_filt", 32'(n), 32'd10);
        chk("irq_filt_pre", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq_filt", 32'(irq), 32'h1);
        repeat (8) @(negedge clk);

        // Fall edge: core_in drops at edge 10, status sets at edge 11 with the W1C
        pad_y[2] = 1'b0;
        wait_in(2, 1'b0, n);
        chk("lat_fall", 32'(n), 32'd10);
        cfg_we    = 1'b1;
        cfg_addr  = 4'd8;
        cfg_wdata = 32'h4;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("irq_setwins", 32'(irq), 32'h1);
        rd(8, 32'h4, "status_setwins");
        wr(2, 32'h40);
        rd(8, 32'h4, "status_keep");
        wr(8, 32'h4);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd(8, 32'h0, "status_clr");

        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_re    = 1'b1;
        cfg_addr  = 4'd1;
        cfg_wdata = 32'h15;
        tag_q.push_back("rw_old");
        exp_q.push_back(32'h38);
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_re = 1'b0;
        rd(1, 32'h15, "rw_new");

        wr(5, 32'h01);
        core_out[5] = 1'b1;
        #1 chk("oe5_pre", 32'(pad_oe[5]), 32'h1);
        @(negedge clk);
        pad_y[4] = 1'b0;
        repeat (5) @(negedge clk);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        wr(6, 32'h40);
        @(negedge clk);
        pad_y[6] = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_oe", 32'(pad_oe), 32'h00);
        chk("arst_ie", 32'(pad_ie), 32'hFF);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_rdata", cfg_rdata, 32'h0);
        chk("arst_core_in", 32'(core_in), 32'h0);
        pad_y[6] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr(6, 32'h40);
        @(negedge clk);
        pad_y[6] = 1'b1;
        wait_in(6, 1'b1, n);
        chk("lat_after_rst", 32'(n), 32'd10);
        rd(5, 32'h0, "cfg5_rst");

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
